// File: rtl/asy_fifo_pkg.sv
// asy_fifo_pkg: shared types and constants for the async FIFO read side
//   occ_t  : skid buffer occupancy
//   RD_LAT : FIFO read-port latency in rd_clk cycles
package asy_fifo_pkg;
    typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_t;
    localparam int RD_LAT = 1;
endpackage

// File: rtl/rd_skid_buf.sv
// rd_skid_buf: 2-entry in-order buffer between the FIFO read port and the output stream
//   clk_i, rst_ni          : clock, async active-low reset
//   push_i, push_data_i    : capture a word arriving from the FIFO
//   pop_i                  : head consumed downstream (only meaningful while valid_o)
//   flush_i                : empty the buffer, overriding push/pop
//   occ_o, head_o, valid_o : occupancy, head word, head valid
module rd_skid_buf
    import asy_fifo_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [N-1:0] push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output occ_t         occ_o,
    output logic [N-1:0] head_o,
    output logic         valid_o
);
    occ_t occ_q, occ_d;
    logic [N-1:0] head_q, head_d, tail_q, tail_d;
    always_comb begin
        occ_d = flush_i ? OCC_EMPTY : occ_t'({1'b0, occ_q} + {1'b0, push_i} - {1'b0, pop_i});
        // push with pop can only happen in ONE, so the arriving word replaces the head
        head_d = (pop_i && occ_q == OCC_TWO) ? tail_q
               : (push_i && (occ_q == OCC_EMPTY || pop_i)) ? push_data_i : head_q;
        tail_d = (push_i && occ_q == OCC_ONE && !pop_i) ? push_data_i : tail_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end
    assign occ_o   = occ_q;
    assign head_o  = head_q;
    assign valid_o = occ_q != OCC_EMPTY;
endmodule

// File: rtl/asy_fifo_reader.sv
// asy_fifo_reader: read-domain drain engine turning FIFO reads into a valid/ready stream
//   rd_clk, rd_rst                 : clock, async active-low reset
//   fifo_Empty, rd_data, rd_en     : FIFO read port (data one cycle after rd_en)
//   flush                          : discard buffered and in-flight words
//   out_data, out_valid, out_ready : downstream stream
//   word_cnt                       : popped-word count, wraps
module asy_fifo_reader
    import asy_fifo_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic             fifo_Empty,
    input  logic [N-1:0]     rd_data,
    output logic             rd_en,
    input  logic             flush,
    output logic [N-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_cnt
);
    occ_t occ;
    logic pop, push;
    logic [RD_LAT-1:0] pend_q, pend_d;
    logic drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] lvl;
    rd_skid_buf #(.N(N)) u_buf (
        .clk_i       (rd_clk),
        .rst_ni      (rd_rst),
        .push_i      (push),
        .push_data_i (rd_data),
        .pop_i       (pop),
        .flush_i     (flush),
        .occ_o       (occ),
        .head_o      (out_data),
        .valid_o     (out_valid)
    );
    always_comb begin
        pop    = out_valid & out_ready;
        push   = pend_q[0] & ~drop_q;
        // words held plus the one in flight, after this cycle's pop; must leave room for one more
        lvl    = {1'b0, occ} + {2'b0, pend_q[0]} - {2'b0, pop};
        rd_en  = rd_rst & ~flush & ~fifo_Empty & (lvl < 3'd2);
        pend_d = RD_LAT'(rd_en);
        drop_d = flush & pend_q[0];
        cnt_d  = cnt_q + CNT_W'(pop);
    end
    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            pend_q <= '0;
            drop_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            drop_q <= drop_d;
            cnt_q  <= cnt_d;
        end
    end
    assign word_cnt = cnt_q;
endmodule

// File: tb/tb_asy_fifo_reader.sv
// tb_asy_fifo_reader: directed and random stream checks against a queue model of the FIFO and delivered words
module tb_asy_fifo_reader;
    logic rd_clk = 1'b0;
    logic rd_rst, fifo_Empty, flush, out_ready;
    logic rd_en, out_valid, rd_en4, out_valid4;
    logic [7:0] rd_data, out_data, out_data4;
    logic [15:0] word_cnt;
    logic [3:0] word_cnt4;
    int n_cmp = 0, n_bad = 0, cnt = 0;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic rd_last, pv, pr, pfl;
    logic [7:0] pd;

    always #5 rd_clk = ~rd_clk;

    asy_fifo_reader #(.N(8), .CNT_W(16)) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_Empty(fifo_Empty), .rd_data(rd_data),
        .rd_en(rd_en), .flush(flush), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .word_cnt(word_cnt)
    );
    asy_fifo_reader #(.N(8), .CNT_W(4)) dut4 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_Empty(fifo_Empty), .rd_data(rd_data),
        .rd_en(rd_en4), .flush(flush), .out_data(out_data4), .out_valid(out_valid4),
        .out_ready(out_ready), .word_cnt(word_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // one rd_clk cycle: drive, check against the model, then advance the FIFO read port
    task automatic cyc(input logic rdy, input logic fl);
        int pop;
        logic erd, ev;
        out_ready  = rdy;
        flush      = fl;
        fifo_Empty = (fq.size() == 0);
        #1;
        ev  = (int'(exp_q.size()) - int'(rd_last)) > 0;
        pop = (ev && rdy) ? 1 : 0;
        chk("out_valid", out_valid, ev);
        chk("out_valid4", out_valid4, ev);
        if (pv && !pr && !pfl && ev) chk("hold", out_data, pd);
        erd = !fl && !fifo_Empty && (int'(exp_q.size()) - pop < 2);
        chk("rd_en", rd_en, erd);
        chk("rd_en4", rd_en4, erd);
        chk("word_cnt", word_cnt, cnt & 16'hffff);
        chk("word_cnt4", word_cnt4, cnt & 15);
        if (pop != 0) begin
            chk("out_data", out_data, exp_q[0]);
            chk("out_data4", out_data4, exp_q[0]);
            void'(exp_q.pop_front());
            cnt++;
        end
        if (fl) exp_q.delete();
        pv = ev; pr = rdy; pfl = fl; pd = out_data;
        rd_last = erd;
        @(posedge rd_clk);
        #1;
        if (erd) begin
            rd_data = fq.pop_front();
            exp_q.push_back(rd_data);
        end else rd_data = 8'($urandom);
    endtask

    task automatic do_rst();
        rd_rst = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_data", out_data, 0);
        chk("rst_cnt", word_cnt, 0);
        chk("rst_cnt4", word_cnt4, 0);
        exp_q.delete();
        cnt = 0; rd_last = 1'b0; pv = 1'b0;
        @(posedge rd_clk);
        #1;
        rd_data = 8'($urandom);
        rd_rst  = 1'b1;
    endtask

    initial begin
        rd_rst = 1'b0; flush = 1'b0; out_ready = 1'b0; fifo_Empty = 1'b1; rd_data = '0;
        rd_last = 1'b0; pv = 1'b0; pr = 1'b0; pfl = 1'b0; pd = '0;
        do_rst();
        fq = '{8'h11, 8'h22, 8'h33};
        repeat (8) cyc(1'b1, 1'b0);
        chk("tp1_cnt", word_cnt, 3);
        for (int i = 0; i < 5; i++) fq.push_back(8'(8'h50 + i));
        repeat (6) cyc(1'b0, 1'b0);
        chk("tp2_head", out_data, 8'h50);
        chk("tp2_left", fq.size(), 3);
        repeat (12) cyc(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) fq.push_back(8'(8'h80 + i));
        for (int i = 0; i < 44; i++) cyc(i % 2 == 0, 1'b0);
        chk("tp3_cnt", word_cnt, 24);
        fq = '{8'hA0, 8'hA1, 8'h44, 8'h45};
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        chk("tp4_valid", out_valid, 1);
        chk("tp4_head", out_data, 8'h44);
        repeat (4) cyc(1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_rst();
            if ($urandom_range(1) == 0) fq.push_back(8'($urandom));
            cyc(1'($urandom_range(1)), $urandom_range(15) == 0);
        end
        repeat (12) cyc(1'b1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
